// File: rtl/sram_port_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port, one-cycle-latency SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic                sram_clken,
  input  logic [DATA_W-1:0]   sram_readdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  owner_t     owner, owner_next;
  logic [7:0] hold_cnt;
  logic       req0, req1, acc0, acc1, accept;
  logic       sel_read, sel_write, hold_ok, pick_m1;
  logic       rd_pend, rd_tag;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  // Grants are masked during reset so no SRAM access happens in the reset cycle.
  assign acc0   = !reset && (owner == OWN_M0) && req0;
  assign acc1   = !reset && (owner == OWN_M1) && req1;
  assign accept = acc0 | acc1;

  assign m0_waitrequest = reset || (owner != OWN_M0);
  assign m1_waitrequest = reset || (owner != OWN_M1);

  always_comb begin
    sram_address    = m0_address;
    sram_byteenable = m0_byteenable;
    sram_writedata  = m0_writedata;
    sel_read        = m0_read;
    sel_write       = m0_write;
    if (owner == OWN_M1) begin
      sram_address    = m1_address;
      sram_byteenable = m1_byteenable;
      sram_writedata  = m1_writedata;
      sel_read        = m1_read;
      sel_write       = m1_write;
    end
  end

  assign sram_chipselect = accept;
  assign sram_write      = accept & sel_write;
  assign sram_clken      = 1'b1;

  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;
  assign m0_readdatavalid = rd_pend && !rd_tag && !reset;
  assign m1_readdatavalid = rd_pend &&  rd_tag && !reset;

`ifdef SRAM_ARB_RR_EN
  owner_t last_owner;
  assign pick_m1 = (last_owner == OWN_M0);
`else
  assign pick_m1 = 1'b0;
`endif

  always_comb begin
    owner_next = OWN_NONE;
    hold_ok    = ({1'b0, hold_cnt} + {8'd0, accept}) < 9'(MAX_HOLD);
    unique case (owner)
      OWN_M0: begin
        if (req0 && (!req1 || hold_ok)) owner_next = OWN_M0;
        else if (req1)                  owner_next = OWN_M1;
      end
      OWN_M1: begin
        if (req1 && (!req0 || hold_ok)) owner_next = OWN_M1;
        else if (req0)                  owner_next = OWN_M0;
      end
      default: begin
        if (req0 && req1) owner_next = pick_m1 ? OWN_M1 : OWN_M0;
        else if (req0)    owner_next = OWN_M0;
        else if (req1)    owner_next = OWN_M1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= OWN_NONE;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_tag   <= 1'b0;
    end else begin
      owner <= owner_next;
      // Saturate rather than wrap so an uncontended owner cannot regain a fresh quota.
      if (owner_next != owner)
        hold_cnt <= '0;
      else if (accept && (hold_cnt != '1))
        hold_cnt <= hold_cnt + 8'd1;
      rd_pend <= accept & sel_read & ~sel_write;
      rd_tag  <= (owner == OWN_M1);
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)
      last_owner <= OWN_M1;
    else if (owner_next != OWN_NONE)
      last_owner <= owner_next;
  end
`endif

endmodule
